mips_multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB,

---
 rtl/mips_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: j 2, beq 3, R/addi/sw 4, lw 5 cycles with zero-wait memory.
// Stalls in FETCH/MEM until mem_ack; halts on illegal instruction or ack timeout.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d, fn_q, fn_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R:                          is_legal = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: is_legal = 1'b1;
            default:                       is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] fn_to_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   fn_to_alu = 3'd1;
            6'h24:   fn_to_alu = 3'd2;
            6'h25:   fn_to_alu = 3'd3;
            6'h2A:   fn_to_alu = 3'd4;
            default: fn_to_alu = 3'd0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        fn_d       = fn_q;
        wait_d     = wait_q;
        err_d      = err_q;
        ret_d      = ret_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 3'd0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    wait_d   = '0;
                    state_d  = S_DECODE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d >= TMO) begin
                        err_d   = 2'd2;
                        state_d = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                // Decisions here use the live IR fields; they are latched for later states.
                op_d      = opcode;
                fn_d      = funct;
                alu_src_b = 2'd3;
                if (!is_legal(opcode, funct)) begin
                    err_d   = 2'd1;
                    state_d = S_HALT;
                end else if (opcode == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    ret_d    = ret_q + CNT_W'(1);
                    wait_d   = '0;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (op_q)
                    OP_R: begin
                        alu_op  = fn_to_alu(fn_q);
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = 2'd2;
                        wait_d    = '0;
                        state_d   = S_MEM;
                    end
                    OP_ADDI: begin
                        alu_src_b = 2'd2;
                        state_d   = S_WB;
                    end
                    OP_BEQ: begin
                        alu_op   = 3'd1;
                        pc_write = zero;
                        pc_src   = 2'd1;
                        ret_d    = ret_q + CNT_W'(1);
                        wait_d   = '0;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        err_d   = 2'd1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_SW);
                if (mem_ack) begin
                    wait_d = '0;
                    if (op_q == OP_SW) begin
                        ret_d   = ret_q + CNT_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d >= TMO) begin
                        err_d   = 2'd2;
                        state_d = S_HALT;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R);
                mem_to_reg = (op_q == OP_LW);
                ret_d      = ret_q + CNT_W'(1);
                wait_d     = '0;
                state_d    = S_FETCH;
            end
            default: ;
        endcase
        // Reset kills any outstanding access without waiting for a clock edge.
        if (RST) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign err     = err_q;
    assign retired = ret_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with hand-computed expectations.
module tb_mips_multicycle_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ack;
    logic        mem_req, mem_we, ir_write, pc_write, alu_src_a;
    logic [1:0]  pc_src, alu_src_b, err;
    logic [2:0]  alu_op, state;
    logic        reg_write, reg_dst, mem_to_reg, halted;
    logic [31:0] retired;
    int          n_vec = 0;
    int          n_err = 0;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .halted(halted), .err(err), .retired(retired)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ack = 1'b1;
        // 1: reset
        step(); step();
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);
        RST = 1'b0;
        #1;
        // 2: R-type add
        chk("r_fetch_state", state, 0);
        chk("r_fetch_req", mem_req, 1);
        chk("r_fetch_irw", ir_write, 1);
        chk("r_fetch_srcb", alu_src_b, 1);
        step();
        chk("r_decode_state", state, 1);
        chk("r_decode_regw", reg_write, 0);
        chk("r_decode_srcb", alu_src_b, 3);
        step();
        chk("r_exec_state", state, 2);
        chk("r_exec_srca", alu_src_a, 1);
        chk("r_exec_aluop", alu_op, 0);
        chk("r_exec_regw", reg_write, 0);
        step();
        chk("r_wb_state", state, 4);
        chk("r_wb_regw", reg_write, 1);
        chk("r_wb_regdst", reg_dst, 1);
        chk("r_wb_m2r", mem_to_reg, 0);
        step();
        chk("r_done_state", state, 0);
        chk("r_retired", retired, 1);
        // 3: lw with 3-cycle memory delay
        opcode = 6'h23; funct = 6'h00;
        step();
        chk("lw_decode", state, 1);
        mem_ack = 1'b0;
        step();
        chk("lw_exec_srcb", alu_src_b, 2);
        step();
        chk("lw_mem_state", state, 3);
        chk("lw_mem_req", mem_req, 1);
        chk("lw_mem_we", mem_we, 0);
        step(); step(); step();
        chk("lw_mem_stall", state, 3);
        mem_ack = 1'b1;
        #1;
        step();
        chk("lw_wb_state", state, 4);
        chk("lw_wb_m2r", mem_to_reg, 1);
        chk("lw_wb_regdst", reg_dst, 0);
        step();
        chk("lw_retired", retired, 2);
        // 4: beq taken and not taken
        opcode = 6'h04; zero = 1'b1;
        step(); step();
        chk("beq1_exec", state, 2);
        chk("beq1_pcw", pc_write, 1);
        chk("beq1_pcsrc", pc_src, 1);
        chk("beq1_aluop", alu_op, 1);
        step();
        chk("beq1_retired", retired, 3);
        zero = 1'b0;
        step(); step();
        chk("beq0_pcw", pc_write, 0);
        step();
        chk("beq0_state", state, 0);
        chk("beq0_retired", retired, 4);
        // jump
        opcode = 6'h02;
        step();
        chk("j_pcw", pc_write, 1);
        chk("j_pcsrc", pc_src, 2);
        step();
        chk("j_state", state, 0);
        chk("j_retired", retired, 5);
        // sw
        opcode = 6'h2B;
        step(); step(); step();
        chk("sw_mem_we", mem_we, 1);
        chk("sw_mem_req", mem_req, 1);
        step();
        chk("sw_retired", retired, 6);
        // addi
        opcode = 6'h08;
        step(); step(); step();
        chk("addi_wb_regw", reg_write, 1);
        chk("addi_wb_regdst", reg_dst, 0);
        step();
        chk("addi_retired", retired, 7);
        // 5: illegal opcode
        opcode = 6'h3F;
        step(); step();
        chk("ill_state", state, 5);
        chk("ill_err", err, 1);
        chk("ill_halted", halted, 1);
        repeat (20) step();
        chk("ill_hold_halted", halted, 1);
        chk("ill_hold_err", err, 1);
        chk("ill_hold_req", mem_req, 0);
        chk("ill_hold_retired", retired, 7);
        RST = 1'b1;
        #1;
        chk("rst_async_state", state, 0);
        chk("rst_async_err", err, 0);
        chk("rst_async_retired", retired, 0);
        step();
        RST = 1'b0;
        // illegal R-type funct
        opcode = 6'h00; funct = 6'h21;
        step(); step();
        chk("illfn_err", err, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        // 6: fetch timeout
        opcode = 6'h00; funct = 6'h20; mem_ack = 1'b0;
        repeat (14) step();
        chk("tmo_wait_state", state, 0);
        step();
        chk("tmo_state", state, 5);
        chk("tmo_err", err, 2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        repeat (14) step();
        mem_ack = 1'b1;
        #1;
        chk("tmo_lim_irw", ir_write, 1);
        step();
        chk("tmo_lim_state", state, 1);
        chk("tmo_lim_err", err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
